// File: rtl/sr_latch_pkg.sv
// Shared constants for the clocked SR latch bank: conflict-resolution modes
// and the width helper for the glitch-filter counter.
package sr_latch_pkg;

   localparam logic [1:0] MODE_RST_DOM = 2'b00;
   localparam logic [1:0] MODE_SET_DOM = 2'b01;
   localparam logic [1:0] MODE_HOLD    = 2'b10;
   localparam logic [1:0] MODE_TOGGLE  = 2'b11;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

   // Counter must hold 0..FILT_CYCLES-1; never narrower than one bit.
   function automatic int filt_width(input int filt_cycles);
      int w;
      w = clog2(filt_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sr_latch_bank_if.sv
// Pin bundle between the top-level wrapper and the latch bank.
// All signals are plain levels: there is no valid/ready handshake here.
interface sr_latch_bank_if #(
   parameter int N_CH = 4
);
   logic            ena;
   logic [N_CH-1:0] s;
   logic [N_CH-1:0] r;
   logic [1:0]      mode;
   logic            clr_conflict;
   logic [N_CH-1:0] q;
   logic [N_CH-1:0] qb;
   logic [N_CH-1:0] changed;
   logic [N_CH-1:0] conflict;

   modport master (
      output ena, s, r, mode, clr_conflict,
      input  q, qb, changed, conflict
   );

   modport slave (
      input  ena, s, r, mode, clr_conflict,
      output q, qb, changed, conflict
   );
endinterface

// File: rtl/sr_input_filter.sv
// Single-bit synchroniser followed by a consecutive-cycle glitch filter.
// The filtered value only moves after FILT_CYCLES agreeing synchronised samples.
module sr_input_filter
   import sr_latch_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   generate
      if (FILT_CYCLES == 0) begin : g_bypass
         assign dout = sync_out;
      end else begin : g_filter
         localparam int FILT_W = filt_width(FILT_CYCLES);

         logic              filt;
         logic [FILT_W-1:0] cnt;

         // Any return to agreement before the final count discards progress.
         always_ff @(posedge clk) begin
            if (rst) begin
               filt <= 1'b0;
               cnt  <= '0;
            end else if (sync_out == filt) begin
               cnt  <= '0;
            end else if (cnt == FILT_W'(FILT_CYCLES - 1)) begin
               filt <= sync_out;
               cnt  <= '0;
            end else begin
               cnt  <= cnt + FILT_W'(1);
            end
         end

         assign dout = filt;
      end
   endgenerate

endmodule

// File: rtl/sr_latch_bank.sv
// Clocked bank of set/reset latches with per-input synchroniser and glitch
// filter, selectable conflict resolution, change strobes and sticky conflict flags.
module sr_latch_bank
   import sr_latch_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 3
) (
   input logic            clk,
   input logic            rst,
   sr_latch_bank_if.slave bus
);

   logic [N_CH-1:0] f_s;
   logic [N_CH-1:0] f_r;
   logic [N_CH-1:0] q_r;
   logic [N_CH-1:0] q_next;
   logic [N_CH-1:0] changed_r;
   logic [N_CH-1:0] conflict_r;
   logic [N_CH-1:0] conflict_set;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         sr_input_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES)
         ) u_filt_s (
            .clk  (clk),
            .rst  (rst),
            .din  (bus.s[gi]),
            .dout (f_s[gi])
         );

         sr_input_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES)
         ) u_filt_r (
            .clk  (clk),
            .rst  (rst),
            .din  (bus.r[gi]),
            .dout (f_r[gi])
         );
      end
   endgenerate

   always_comb begin
      q_next = q_r;
      for (int i = 0; i < N_CH; i++) begin
         case ({f_s[i], f_r[i]})
            2'b10:   q_next[i] = 1'b1;
            2'b01:   q_next[i] = 1'b0;
            2'b11: begin
               case (bus.mode)
                  MODE_RST_DOM: q_next[i] = 1'b0;
                  MODE_SET_DOM: q_next[i] = 1'b1;
                  MODE_HOLD:    q_next[i] = q_r[i];
                  default:      q_next[i] = ~q_r[i];
               endcase
            end
            default: q_next[i] = q_r[i];
         endcase
      end
   end

   assign conflict_set = {N_CH{bus.ena}} & f_s & f_r;

   // A new conflict in the same cycle as a clear keeps its flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r        <= '0;
         changed_r  <= '0;
         conflict_r <= '0;
      end else begin
         if (bus.ena) begin
            q_r       <= q_next;
            changed_r <= q_next ^ q_r;
         end else begin
            changed_r <= '0;
         end
         conflict_r <= (conflict_r & ~{N_CH{bus.clr_conflict}}) | conflict_set;
      end
   end

   assign bus.q        = q_r;
   assign bus.qb       = ~q_r;
   assign bus.changed  = changed_r;
   assign bus.conflict = conflict_r;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench for sr_latch_bank: default build plus a filter-bypass build.
module tb_sr_latch_bank;
   import sr_latch_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   sr_latch_bank_if #(.N_CH(4)) bus  ();
   sr_latch_bank_if #(.N_CH(4)) bus2 ();

   sr_latch_bank #(.N_CH(4), .SYNC_STAGES(2), .FILT_CYCLES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   sr_latch_bank #(.N_CH(4), .SYNC_STAGES(2), .FILT_CYCLES(0)) dut_nf (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         n_cmp++;
         if (bus.q !== 4'b0000) begin n_err++; $display("FAIL reset_q: got %b want 0000", bus.q); end
         n_cmp++;
         if (bus.qb !== 4'b1111) begin n_err++; $display("FAIL reset_qb: got %b want 1111", bus.qb); end
         n_cmp++;
         if (bus.changed !== 4'b0000) begin n_err++; $display("FAIL reset_changed: got %b want 0000", bus.changed); end
         n_cmp++;
         if (bus.conflict !== 4'b0000) begin n_err++; $display("FAIL reset_conflict: got %b want 0000", bus.conflict); end
      end
   endtask

   task automatic test_set_latency();
      bus.s[0] = 1'b1;
      step(5);
      n_cmp++;
      if (bus.q[0] !== 1'b0) begin n_err++; $display("FAIL set_early: q0 got %b want 0", bus.q[0]); end
      step(1);
      n_cmp++;
      if (bus.q[0] !== 1'b1) begin n_err++; $display("FAIL set_q: q0 got %b want 1", bus.q[0]); end
      n_cmp++;
      if (bus.changed !== 4'b0001) begin n_err++; $display("FAIL set_changed: got %b want 0001", bus.changed); end
      n_cmp++;
      if (bus.qb[0] !== 1'b0) begin n_err++; $display("FAIL set_qb: qb0 got %b want 0", bus.qb[0]); end
      step(1);
      n_cmp++;
      if (bus.changed !== 4'b0000) begin n_err++; $display("FAIL set_changed_pulse: got %b want 0000", bus.changed); end
      step(3);
      bus.s[0] = 1'b0;
      step(10);
      n_cmp++;
      if (bus.q !== 4'b0001) begin n_err++; $display("FAIL set_hold: q got %b want 0001", bus.q); end
   endtask

   task automatic test_glitch_and_reset_input();
      bus.r[0] = 1'b1;
      step(2);
      bus.r[0] = 1'b0;
      step(8);
      n_cmp++;
      if (bus.q[0] !== 1'b1) begin n_err++; $display("FAIL glitch_reject: q0 got %b want 1", bus.q[0]); end
      bus.r[0] = 1'b1;
      step(4);
      bus.r[0] = 1'b0;
      step(1);
      n_cmp++;
      if (bus.q[0] !== 1'b1) begin n_err++; $display("FAIL rst_early: q0 got %b want 1", bus.q[0]); end
      step(1);
      n_cmp++;
      if (bus.q[0] !== 1'b0) begin n_err++; $display("FAIL rst_q: q0 got %b want 0", bus.q[0]); end
      n_cmp++;
      if (bus.changed !== 4'b0001) begin n_err++; $display("FAIL rst_changed: got %b want 0001", bus.changed); end
      step(1);
      n_cmp++;
      if (bus.changed !== 4'b0000) begin n_err++; $display("FAIL rst_changed_pulse: got %b want 0000", bus.changed); end
   endtask

   task automatic test_conflict_modes();
      logic exp_q;
      bus.mode = MODE_RST_DOM;
      bus.s[2] = 1'b1;
      step(6);
      n_cmp++;
      if (bus.q[2] !== 1'b1) begin n_err++; $display("FAIL cm_preset: q2 got %b want 1", bus.q[2]); end
      bus.r[2] = 1'b1;
      step(5);
      n_cmp++;
      if (bus.conflict[2] !== 1'b0) begin n_err++; $display("FAIL cm_no_early_conflict: got %b want 0", bus.conflict[2]); end
      step(1);
      n_cmp++;
      if (bus.q[2] !== 1'b0) begin n_err++; $display("FAIL cm_rst_dom: q2 got %b want 0", bus.q[2]); end
      n_cmp++;
      if (bus.conflict !== 4'b0100) begin n_err++; $display("FAIL cm_conflict: got %b want 0100", bus.conflict); end
      bus.mode = MODE_SET_DOM;
      step(1);
      n_cmp++;
      if (bus.q[2] !== 1'b1) begin n_err++; $display("FAIL cm_set_dom: q2 got %b want 1", bus.q[2]); end
      bus.mode = MODE_HOLD;
      step(3);
      n_cmp++;
      if (bus.q[2] !== 1'b1) begin n_err++; $display("FAIL cm_hold: q2 got %b want 1", bus.q[2]); end
      n_cmp++;
      if (bus.changed[2] !== 1'b0) begin n_err++; $display("FAIL cm_hold_changed: got %b want 0", bus.changed[2]); end
      bus.mode = MODE_TOGGLE;
      exp_q = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_q = ~exp_q;
         step(1);
         n_cmp++;
         if (bus.q[2] !== exp_q) begin n_err++; $display("FAIL cm_toggle_%0d: q2 got %b want %b", k, bus.q[2], exp_q); end
         n_cmp++;
         if (bus.changed[2] !== 1'b1) begin n_err++; $display("FAIL cm_toggle_changed_%0d: got %b want 1", k, bus.changed[2]); end
      end
      bus.clr_conflict = 1'b1;
      step(1);
      bus.clr_conflict = 1'b0;
      n_cmp++;
      if (bus.conflict[2] !== 1'b1) begin n_err++; $display("FAIL cm_set_wins: got %b want 1", bus.conflict[2]); end
      bus.s[2] = 1'b0;
      bus.r[2] = 1'b0;
      step(8);
      n_cmp++;
      if (bus.conflict[2] !== 1'b1) begin n_err++; $display("FAIL cm_sticky: got %b want 1", bus.conflict[2]); end
      bus.clr_conflict = 1'b1;
      step(1);
      bus.clr_conflict = 1'b0;
      n_cmp++;
      if (bus.conflict !== 4'b0000) begin n_err++; $display("FAIL cm_clear: got %b want 0000", bus.conflict); end
      bus.mode = MODE_RST_DOM;
   endtask

   task automatic test_enable();
      bus.ena  = 1'b0;
      bus.s[1] = 1'b1;
      bus.s[3] = 1'b1;
      bus.r[3] = 1'b1;
      step(10);
      n_cmp++;
      if (bus.q[1] !== 1'b0) begin n_err++; $display("FAIL ena_hold: q1 got %b want 0", bus.q[1]); end
      n_cmp++;
      if (bus.changed !== 4'b0000) begin n_err++; $display("FAIL ena_changed: got %b want 0000", bus.changed); end
      n_cmp++;
      if (bus.conflict !== 4'b0000) begin n_err++; $display("FAIL ena_conflict: got %b want 0000", bus.conflict); end
      bus.s[3] = 1'b0;
      bus.r[3] = 1'b0;
      step(8);
      bus.ena = 1'b1;
      step(1);
      n_cmp++;
      if (bus.q[1] !== 1'b1) begin n_err++; $display("FAIL ena_release: q1 got %b want 1", bus.q[1]); end
      n_cmp++;
      if (bus.changed !== 4'b0010) begin n_err++; $display("FAIL ena_release_changed: got %b want 0010", bus.changed); end
      bus.s[1] = 1'b0;
   endtask

   task automatic test_no_filter();
      bus2.s[3] = 1'b1;
      step(1);
      bus2.s[3] = 1'b0;
      step(1);
      n_cmp++;
      if (bus2.q !== 4'b0000) begin n_err++; $display("FAIL nf_early: q got %b want 0000", bus2.q); end
      step(1);
      n_cmp++;
      if (bus2.q !== 4'b1000) begin n_err++; $display("FAIL nf_q: q got %b want 1000", bus2.q); end
      n_cmp++;
      if (bus2.changed !== 4'b1000) begin n_err++; $display("FAIL nf_changed: got %b want 1000", bus2.changed); end
      step(2);
      n_cmp++;
      if (bus2.q !== 4'b1000) begin n_err++; $display("FAIL nf_hold: q got %b want 1000", bus2.q); end
   endtask

   task automatic test_reset_mid_count();
      bus.s[3] = 1'b1;
      step(3);
      rst      = 1'b1;
      bus.s[3] = 1'b0;
      step(1);
      rst = 1'b0;
      n_cmp++;
      if (bus.q !== 4'b0000) begin n_err++; $display("FAIL mid_rst_q: got %b want 0000", bus.q); end
      n_cmp++;
      if (bus.qb !== 4'b1111) begin n_err++; $display("FAIL mid_rst_qb: got %b want 1111", bus.qb); end
      n_cmp++;
      if (bus2.q !== 4'b0000) begin n_err++; $display("FAIL mid_rst_nf_q: got %b want 0000", bus2.q); end
      step(10);
      n_cmp++;
      if (bus.q[3] !== 1'b0) begin n_err++; $display("FAIL mid_rst_abort: q3 got %b want 0", bus.q[3]); end
      n_cmp++;
      if (bus.changed !== 4'b0000) begin n_err++; $display("FAIL mid_rst_changed: got %b want 0000", bus.changed); end
   endtask

   initial begin
      n_cmp             = 0;
      n_err             = 0;
      rst               = 1'b1;
      bus.ena           = 1'b1;
      bus.s             = '0;
      bus.r             = '0;
      bus.mode          = MODE_RST_DOM;
      bus.clr_conflict  = 1'b0;
      bus2.ena          = 1'b1;
      bus2.s            = '0;
      bus2.r            = '0;
      bus2.mode         = MODE_RST_DOM;
      bus2.clr_conflict = 1'b0;

      test_reset();
      test_set_latency();
      test_glitch_and_reset_input();
      test_conflict_modes();
      test_enable();
      test_no_filter();
      test_reset_mid_count();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
